// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - request/result bundle for the shift sequencer
interface shift_sequencer_if;
  logic        ctrl_start;
  logic [1:0]  ctrl_op;
  logic [4:0]  ctrl_shiftamt;
  logic [31:0] data_operandA;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic        data_exception;
  logic        busy;

  modport master (
    output ctrl_start, ctrl_op, ctrl_shiftamt, data_operandA,
    input  data_result, data_resultRDY, data_exception, busy
  );

  modport slave (
    input  ctrl_start, ctrl_op, ctrl_shiftamt, data_operandA,
    output data_result, data_resultRDY, data_exception, busy
  );
endinterface

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle barrel-stage shifter (sll/sra/srl)
// One power-of-two stage per cycle, largest remaining stage first.
module shift_sequencer (
  input  logic              clock,
  input  logic              reset,
  shift_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_work;
  logic [1:0]  r_op;
  logic [4:0]  r_amt;
  logic [4:0]  w_stage;
  logic [4:0]  w_amt_next;
  logic [31:0] w_work_shifted;
  logic        w_accept;

  assign w_accept = (r_state == S_IDLE) && bus.ctrl_start;

  // Stage weight equals the highest set bit of the remaining amount.
  always_comb begin
    w_stage = 5'd0;
    if (r_amt[4])      w_stage = 5'd16;
    else if (r_amt[3]) w_stage = 5'd8;
    else if (r_amt[2]) w_stage = 5'd4;
    else if (r_amt[1]) w_stage = 5'd2;
    else if (r_amt[0]) w_stage = 5'd1;
    w_amt_next = r_amt & ~w_stage;
  end

  always_comb begin
    w_work_shifted = r_work;
    case (r_op)
      2'b00:   w_work_shifted = r_work << w_stage;
      2'b01:   w_work_shifted = 32'($signed(r_work) >>> w_stage);
      2'b10:   w_work_shifted = r_work >> w_stage;
      default: w_work_shifted = r_work;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.ctrl_start) begin
          if ((bus.ctrl_shiftamt == 5'd0) || (bus.ctrl_op == 2'b11))
            w_state_next = S_DONE;
          else
            w_state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_amt_next == 5'd0)
          w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_work <= 32'd0;
      r_op   <= 2'd0;
      r_amt  <= 5'd0;
    end else if (w_accept) begin
      r_work <= bus.data_operandA;
      r_op   <= bus.ctrl_op;
      r_amt  <= bus.ctrl_shiftamt;
    end else if (r_state == S_SHIFT) begin
      r_work <= w_work_shifted;
      r_amt  <= w_amt_next;
    end
  end

  // Outputs decode straight from registered state, so reset clears them at once.
  assign bus.data_result    = r_work;
  assign bus.data_resultRDY = (r_state == S_DONE);
  assign bus.data_exception = (r_state == S_DONE) && (r_op == 2'b11);
  assign bus.busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - scoreboard bench for shift_sequencer
module tb_shift_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b0;

  shift_sequencer_if bus ();

  shift_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] x, input logic [4:0] amt);
    case (op)
      2'b00:   return x << amt;
      2'b01:   return 32'($signed(x) >>> amt);
      2'b10:   return x >> amt;
      default: return x;
    endcase
  endfunction

  function automatic int popc(input logic [4:0] a);
    int n = 0;
    for (int i = 0; i < 5; i++) n += int'(a[i]);
    return n;
  endfunction

  task automatic start_op(input logic [1:0] op, input logic [31:0] x, input logic [4:0] amt);
    exp_t e;
    bus.ctrl_op       = op;
    bus.data_operandA = x;
    bus.ctrl_shiftamt = amt;
    bus.ctrl_start    = 1'b1;
    e.res = model(op, x, amt);
    e.exc = (op == 2'b11);
    e.lat = ((amt == 5'd0) || (op == 2'b11)) ? 1 : popc(amt) + 1;
    sb.push_back(e);
    @(posedge clock); #1;
    bus.ctrl_start    = 1'b0;
    bus.ctrl_op       = 2'($urandom_range(3, 0));
    bus.data_operandA = $urandom;
    bus.ctrl_shiftamt = 5'($urandom_range(31, 0));
  endtask

  task automatic wait_result(input int inject, input string tag);
    exp_t e;
    int   lat;
    logic got;
    e   = sb.pop_front();
    lat = 1;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus.data_resultRDY === 1'b1) begin
        got = 1'b1;
        break;
      end
      check({tag, ":exc_low"}, 32'(bus.data_exception), 32'd0);
      check({tag, ":busy_high"}, 32'(bus.busy), 32'd1);
      if (lat == inject) begin
        bus.ctrl_op       = 2'b10;
        bus.data_operandA = 32'd0;
        bus.ctrl_shiftamt = 5'd1;
        bus.ctrl_start    = 1'b1;
      end
      @(posedge clock); #1;
      bus.ctrl_start = 1'b0;
      lat++;
    end
    check({tag, ":rdy_seen"}, 32'(got), 32'd1);
    check({tag, ":latency"}, 32'(lat), 32'(e.lat));
    check({tag, ":result"}, bus.data_result, e.res);
    check({tag, ":exception"}, 32'(bus.data_exception), 32'(e.exc));
    check({tag, ":busy_done"}, 32'(bus.busy), 32'd1);
    @(posedge clock); #1;
    check({tag, ":rdy_drop"}, 32'(bus.data_resultRDY), 32'd0);
    check({tag, ":busy_drop"}, 32'(bus.busy), 32'd0);
    check({tag, ":exc_drop"}, 32'(bus.data_exception), 32'd0);
    check({tag, ":hold"}, bus.data_result, e.res);
  endtask

  initial begin
    bus.ctrl_start    = 1'b0;
    bus.ctrl_op       = 2'b00;
    bus.ctrl_shiftamt = 5'd0;
    bus.data_operandA = 32'd0;

    #12;
    check("reset:result", bus.data_result, 32'd0);
    check("reset:rdy", 32'(bus.data_resultRDY), 32'd0);
    check("reset:exc", 32'(bus.data_exception), 32'd0);
    check("reset:busy", 32'(bus.busy), 32'd0);

    @(negedge clock);
    reset = 1'b1;
    start_op(2'b00, 32'h0000_0001, 5'd31);
    wait_result(0, "sll31");

    start_op(2'b01, 32'h8000_0000, 5'd4);
    wait_result(0, "sra4");
    start_op(2'b10, 32'h8000_0000, 5'd4);
    wait_result(0, "srl4");

    start_op(2'b00, 32'h1234_5678, 5'd0);
    wait_result(0, "sll0");

    start_op(2'b11, 32'hDEAD_BEEF, 5'd7);
    wait_result(0, "illegal");

    start_op(2'b10, 32'hFFFF_FFFF, 5'd21);
    wait_result(1, "srl21_ignore");
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check("srl21_ignore:no_rdy", 32'(bus.data_resultRDY), 32'd0);
      check("srl21_ignore:idle", 32'(bus.busy), 32'd0);
      check("srl21_ignore:hold", bus.data_result, 32'h0000_07FF);
    end

    start_op(2'b00, 32'hFFFF_FFFF, 5'd31);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    check("abort:result", bus.data_result, 32'd0);
    check("abort:rdy", 32'(bus.data_resultRDY), 32'd0);
    check("abort:exc", 32'(bus.data_exception), 32'd0);
    check("abort:busy", 32'(bus.busy), 32'd0);
    sb.delete();
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      check("abort:no_rdy", 32'(bus.data_resultRDY), 32'd0);
      check("abort:idle", 32'(bus.busy), 32'd0);
    end
    start_op(2'b01, 32'h8000_0001, 5'd1);
    wait_result(0, "after_abort");

    for (int t = 0; t < 16; t++) begin
      start_op(2'($urandom_range(3, 0)), $urandom, 5'($urandom_range(31, 0)));
      wait_result(0, "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have ports: clock  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: ctrl_start  input  1  request strobe, sampled only in IDLE.
REQ-004 SHALL have ports: ctrl_op  input  2  00 sll, 01 sra, 10 srl, 11 illegal.
REQ-005 SHALL have ports: ctrl_shiftamt  input  5  shift amount 0-31.
REQ-006 SHALL have ports: data_operandA  input  32  operand.
REQ-007 SHALL have ports: data_result  output  32  shifted result, registered.
REQ-008 SHALL have ports: data_resultRDY  output  1  one-cycle result-valid pulse.
REQ-009 SHALL have ports: data_exception  output  1  illegal-op flag, pulses with data_resultRDY.
REQ-010 SHALL have ports: busy  output  1  high in SHIFT and DONE.
REQ-011 SHALL have no parameters; widths fixed at 32-bit data and 5-bit amount.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE; encoding free.
REQ-013 IDLE with ctrl_start=1 SHALL latch operand, op and amount into internal registers on that edge.
REQ-014 From IDLE on start, next state SHALL be DONE if amount==0 or op==11, else SHIFT.
REQ-015 In SHIFT, each edge SHALL apply one power-of-two stage, 16/8/4/2/1, for the highest set bit of the remaining amount, then clear that bit.
REQ-016 SHIFT SHALL move to DONE on the edge that clears the last set bit; SHIFT cycles = popcount(amount).
REQ-017 Stage semantics SHALL be as follows: sll fills vacated LSBs with 0; srl fills vacated MSBs with 0; sra fills vacated MSBs with latched bit 31.
REQ-018 DONE SHALL last exactly one cycle, assert data_resultRDY=1, then go to IDLE.
REQ-019 Latency SHALL be popcount(amount)+1 rising edges from the accepting edge to data_resultRDY high. Amount 0 and illegal op give latency 1.
REQ-020 data_result SHALL equal the working register. It SHALL hold its final value after DONE until the next accepted start.
REQ-021 data_result is not guaranteed meaningful while busy=1.
REQ-022 With op==11, data_result SHALL equal data_operandA unchanged, and data_exception=1 SHALL be asserted only during DONE.
REQ-023 data_exception SHALL be 0 in every other cycle.
REQ-024 ctrl_start while busy=1 (SHIFT or DONE) SHALL be ignored, with no latch and no queueing.
REQ-025 Inputs other than ctrl_start SHALL be don't-care except on the accepting edge; changes mid-operation SHALL NOT affect the result.
REQ-026 busy SHALL be 0 in IDLE and 1 in SHIFT and DONE.
REQ-027 The result SHALL match single-cycle x<<amt, x>>amt and $signed(x)>>>amt for all 32-bit x and amt 0-31.

Reset
REQ-028 reset=0 SHALL immediately, without waiting for clock, force: state IDLE, working register 0, latched op/amount 0, data_result=0, data_resultRDY=0, data_exception=0, busy=0.
REQ-029 Reset asserted mid-SHIFT or in DONE SHALL abort the operation; no data_resultRDY pulse follows release.
REQ-030 The first ctrl_start SHALL be accepted on the first rising edge with reset=1.

Verification
REQ-031 sll 0x00000001 amt 31 -> 5 SHIFT cycles, data_resultRDY on edge 6, data_result=0x80000000.
REQ-032 sra 0x80000000 amt 4 -> RDY on edge 2, data_result=0xF8000000; srl same operand and amount -> 0x08000000.
REQ-033 sll 0x12345678 amt 0 -> RDY on edge 1, data_result=0x12345678, busy high for exactly 1 cycle.
REQ-034 op 11, operand 0xDEADBEEF, amt 7 -> RDY and data_exception both high on edge 1, data_result=0xDEADBEEF.
REQ-035 srl 0xFFFFFFFF amt 21 with a second start pulsed mid-SHIFT (operand 0, amt 1) -> second start ignored, RDY on edge 4 with 0x000007FF, then IDLE.
REQ-036 sll 0xFFFFFFFF amt 31, reset=0 after 2 SHIFT edges -> all outputs 0 asynchronously, no RDY after release, new start accepted normally.
